clock_divider_multi: RTL



---
 rtl/clk_div_pkg.sv | 10 +
 rtl/clk_div_channel.sv | 66 ++++++
 rtl/clock_divider_multi.sv | 43 ++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared widths, defaults and the channel-index width helper for the clock divider
package clk_div_pkg;
    localparam int CNT_W_DEF       = 32;
    localparam int DEFAULT_DIV_DEF = 50_000;
    localparam int MAX_CH          = 8;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with shadowed divisor, tick strobe, toggle output and pending flag
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_tick,
    output logic             o_clk,
    output logic             o_pending
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act;
    logic [CNT_W-1:0] r_shd;
    logic             r_tick;
    logic             r_clk;
    logic             r_pend;
    logic [CNT_W-1:0] w_d;
    logic             w_tc;

    assign w_d       = (r_act == '0) ? CNT_W'(1) : r_act;
    assign w_tc      = r_cnt == w_d - CNT_W'(1);
    assign o_tick    = r_tick;
    assign o_clk     = r_clk;
    assign o_pending = r_pend;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_act  <= CNT_W'(DEFAULT_DIV);
            r_shd  <= CNT_W'(DEFAULT_DIV);
            r_tick <= 1'b0;
            r_clk  <= 1'b0;
            r_pend <= 1'b0;
        end else if (i_sync) begin
            r_cnt  <= '0;
            r_act  <= i_wr ? i_val : r_shd;
            r_shd  <= i_wr ? i_val : r_shd;
            r_tick <= 1'b0;
            r_clk  <= 1'b0;
            r_pend <= 1'b0;
        end else if (i_wr && !i_enable) begin
            r_cnt  <= '0;
            r_act  <= i_val;
            r_shd  <= i_val;
            r_tick <= 1'b0;
            r_pend <= 1'b0;
        end else if (i_enable) begin
            // the half-period in flight always finishes on the old divisor
            if (i_wr) r_shd <= i_val;
            if (w_tc && r_pend) r_act <= r_shd;
            r_pend <= i_wr || (r_pend && !w_tc);
            r_cnt  <= w_tc ? '0 : r_cnt + CNT_W'(1);
            r_tick <= w_tc;
            if (w_tc) r_clk <= ~r_clk;
        end else begin
            r_tick <= 1'b0;
        end
    end
endmodule

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH programmable tick/toggle dividers with a shared phase-align sync
module clock_divider_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_CH-1:0]         i_enable,
    input  logic                      i_sync,
    input  logic                      i_div_wr,
    input  logic [ch_w(NUM_CH)-1:0]   i_div_ch,
    input  logic [CNT_W-1:0]          i_div_val,
    output logic [NUM_CH-1:0]         o_tick,
    output logic [NUM_CH-1:0]         o_clk,
    output logic [NUM_CH-1:0]         o_div_pending
);
    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("NUM_CH out of range");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic w_wr;
        // indices with no matching channel select nothing, so such writes vanish
        assign w_wr = i_div_wr && (int'(i_div_ch) == c);
        clk_div_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_enable (i_enable[c]),
            .i_sync   (i_sync),
            .i_wr     (w_wr),
            .i_val    (i_div_val),
            .o_tick   (o_tick[c]),
            .o_clk    (o_clk[c]),
            .o_pending(o_div_pending[c])
        );
    end
endmodule
